// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings, writeback FSM states and default widths.
package axi4_lite_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 64;
    localparam int unsigned DEF_WORD_WIDTH = 32;
    localparam int unsigned DEF_LINE_WIDTH = 512;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ISSUE  = 2'd1,
        WB_WAIT   = 2'd2,
        WB_FINISH = 2'd3
    } t_wb_state;

endpackage

// File: rtl/axi4_lite_line_writeback.sv
// Splits a dirty cache line into words and drives them through the single-word AXI4-Lite write master.
// Optional macro LINE_WB_RETRY_EN: retry a faulting word up to two times before recording the fault.
module axi4_lite_line_writeback
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  wb_req_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [LINE_WIDTH-1:0] wb_line_i,
    output logic                  wb_ready_o,
    output logic                  wb_done_o,
    output logic                  wb_fault_o,
    output logic                  axi_start_write_o,
    output logic [ADDR_WIDTH-1:0] axi_addr_o,
    output logic [WORD_WIDTH-1:0] axi_data_o,
    input  logic                  axi_done_i,
    input  logic                  axi_write_fault_i
);

    localparam int unsigned WORDS      = LINE_WIDTH / WORD_WIDTH;
    localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
    localparam int unsigned OFFS       = $clog2(LINE_WIDTH / 8);
    localparam int unsigned CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    t_wb_state             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sticky_q, sticky_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  retry_take_c;

`ifdef LINE_WB_RETRY_EN
    localparam logic [1:0] MAX_RETRY = 2'd2;
    logic [1:0] retry_q, retry_d;

    assign retry_take_c = axi_write_fault_i && (retry_q < MAX_RETRY);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign retry_take_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:   if (wb_req_i) state_d = WB_ISSUE;
            WB_ISSUE:  state_d = WB_WAIT;
            WB_WAIT: begin
                if (axi_done_i) begin
                    if (retry_take_c || (cnt_q != LAST_CNT)) begin
                        state_d = WB_ISSUE;
                    end else begin
                        state_d = WB_FINISH;
                    end
                end
            end
            WB_FINISH: state_d = WB_IDLE;
            default:   state_d = WB_IDLE;
        endcase
    end

    // Line, base, word counter and sticky fault updates
    always_comb begin
        line_d   = line_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
`ifdef LINE_WB_RETRY_EN
        retry_d  = retry_q;
`endif
        if ((state_q == WB_IDLE) && wb_req_i) begin
            line_d   = wb_line_i;
            base_d   = {wb_addr_i[ADDR_WIDTH-1:OFFS], OFFS'(0)};
            cnt_d    = '0;
            sticky_d = 1'b0;
`ifdef LINE_WB_RETRY_EN
            retry_d  = 2'd0;
`endif
        end else if ((state_q == WB_WAIT) && axi_done_i) begin
            if (retry_take_c) begin
`ifdef LINE_WB_RETRY_EN
                retry_d = retry_q + 2'd1;
`endif
            end else begin
                sticky_d = sticky_q | axi_write_fault_i;
                if (cnt_q != LAST_CNT) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef LINE_WB_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            line_q   <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            line_q   <= line_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    // Outputs decoded from registered state; address/data held from ISSUE through done
    always_comb begin
        wb_ready_o        = (state_q == WB_IDLE);
        wb_done_o         = (state_q == WB_FINISH);
        wb_fault_o        = (state_q == WB_FINISH) && sticky_q;
        axi_start_write_o = (state_q == WB_ISSUE);
        axi_addr_o        = base_q + (ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(WORD_BYTES));
        axi_data_o        = line_q[cnt_q * WORD_WIDTH +: WORD_WIDTH];
    end

endmodule

// File: tb/tb_axi4_lite_line_writeback.sv
// Directed bench for axi4_lite_line_writeback with a behavioural single-word write-master model.
module tb_axi4_lite_line_writeback;

    localparam int unsigned AW    = 64;
    localparam int unsigned WW    = 32;
    localparam int unsigned LW    = 512;
    localparam int unsigned WORDS = LW / WW;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          wb_req_i;
    logic [AW-1:0] wb_addr_i;
    logic [LW-1:0] wb_line_i;
    logic          wb_ready_o, wb_done_o, wb_fault_o, axi_start_write_o;
    logic [AW-1:0] axi_addr_o;
    logic [WW-1:0] axi_data_o;
    logic          axi_done_i, axi_write_fault_i;

    axi4_lite_line_writeback dut (
        .clk_i             (clk_i),
        .arst_i            (arst_i),
        .wb_req_i          (wb_req_i),
        .wb_addr_i         (wb_addr_i),
        .wb_line_i         (wb_line_i),
        .wb_ready_o        (wb_ready_o),
        .wb_done_o         (wb_done_o),
        .wb_fault_o        (wb_fault_o),
        .axi_start_write_o (axi_start_write_o),
        .axi_addr_o        (axi_addr_o),
        .axi_data_o        (axi_data_o),
        .axi_done_i        (axi_done_i),
        .axi_write_fault_i (axi_write_fault_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Write-master model state
    bit            busy = 1'b0;
    int            wait_cnt = 0;
    int            lat = 1;
    logic [AW-1:0] cap_addr;
    logic [WW-1:0] cap_data;
    logic [AW-1:0] fault_addr = '1;
    int            fault_left = 0;
    bit            prev_start = 1'b0;

    logic [AW-1:0] iss_addr[$];
    logic [WW-1:0] iss_data[$];
    int            acc_cyc[$];
    int            done_cyc[$];
    int            wide_cnt = 0;
    int            unstable_cnt = 0;
    int            done_cnt = 0;
    bit            last_fault = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Handshake observer: values sampled just before the edge updates them
    always @(posedge clk_i) begin
        if (!arst_i) begin
            if (wb_ready_o && wb_req_i) acc_cyc.push_back(cyc);
            if (wb_done_o) begin
                done_cnt++;
                last_fault = wb_fault_o;
                done_cyc.push_back(cyc);
            end
        end
    end

    // Write master: done pulse `lat` cycles after start, optional fault on one address
    always @(negedge clk_i) begin
        axi_done_i        = 1'b0;
        axi_write_fault_i = 1'b0;
        if (arst_i) begin
            busy       = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (axi_start_write_o && prev_start) wide_cnt++;
            prev_start = axi_start_write_o;
            if (busy) begin
                if (axi_addr_o !== cap_addr || axi_data_o !== cap_data) unstable_cnt++;
                wait_cnt--;
                if (wait_cnt == 0) begin
                    axi_done_i = 1'b1;
                    busy       = 1'b0;
                    if (cap_addr == fault_addr && fault_left > 0) begin
                        axi_write_fault_i = 1'b1;
                        fault_left--;
                    end
                end
            end
            if (axi_start_write_o) begin
                iss_addr.push_back(axi_addr_o);
                iss_data.push_back(axi_data_o);
                cap_addr = axi_addr_o;
                cap_data = axi_data_o;
                busy     = 1'b1;
                wait_cnt = lat;
            end
        end
    end

    function automatic logic [LW-1:0] mk_line(input logic [WW-1:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < int'(WORDS); k++) l[k*WW +: WW] = base + WW'(k);
        return l;
    endfunction

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clr();
        iss_addr.delete();
        iss_data.delete();
        acc_cyc.delete();
        done_cyc.delete();
        wide_cnt     = 0;
        unstable_cnt = 0;
        done_cnt     = 0;
        last_fault   = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wb_ready_o && n < 500) begin
            step();
            n++;
        end
    endtask

    task automatic start_line(input logic [AW-1:0] addr, input logic [WW-1:0] base);
        wait_ready();
        wb_addr_i = addr;
        wb_line_i = mk_line(base);
        wb_req_i  = 1'b1;
        @(posedge clk_i);
        #1;
        wb_req_i  = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL wait_done: got %0d done pulses, required %0d", done_cnt, target);
        end
    endtask

    task automatic wait_issued(input int target);
        int n = 0;
        while (iss_addr.size() < target && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        arst_i = 1'b1;
        wb_req_i = 1'b0;
        wb_addr_i = '0;
        wb_line_i = '0;
        repeat (2) step();
        checks++;
        if (wb_ready_o !== 1'b1 || wb_done_o !== 1'b0 || wb_fault_o !== 1'b0 ||
            axi_start_write_o !== 1'b0 || axi_addr_o !== '0 || axi_data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b done=%b fault=%b start=%b addr=%h data=%h, required 1 0 0 0 0 0",
                     wb_ready_o, wb_done_o, wb_fault_o, axi_start_write_o, axi_addr_o, axi_data_o);
        end
        arst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        clr();
        lat = 1;
        start_line(64'h1000_0047, 32'hA0);
        wait_done(1, 500);
        checks++;
        if (iss_addr.size() !== 16) begin
            errors++;
            $display("FAIL basic_count: got %0d starts, required 16", iss_addr.size());
        end
        for (int k = 0; k < 16 && k < iss_addr.size(); k++) begin
            checks++;
            if (iss_addr[k] !== 64'h1000_0040 + 64'(4 * k) || iss_data[k] !== 32'hA0 + 32'(k)) begin
                errors++;
                $display("FAIL basic_word%0d: addr=%h data=%h, required addr=%h data=%h", k,
                         iss_addr[k], iss_data[k], 64'h1000_0040 + 64'(4 * k), 32'hA0 + 32'(k));
            end
        end
        checks++;
        if (last_fault !== 1'b0 || wide_cnt !== 0) begin
            errors++;
            $display("FAIL basic_done: fault=%b wide_starts=%0d, required fault=0 wide_starts=0", last_fault, wide_cnt);
        end
    endtask

    task automatic test_single_fault();
        int exp_n;
        bit exp_f;
`ifdef LINE_WB_RETRY_EN
        exp_n = 17;
        exp_f = 1'b0;
`else
        exp_n = 16;
        exp_f = 1'b1;
`endif
        clr();
        fault_addr = 64'h2000_0014;
        fault_left = 1;
        start_line(64'h2000_0000, 32'h100);
        wait_done(1, 500);
        checks++;
        if (iss_addr.size() !== exp_n || last_fault !== exp_f) begin
            errors++;
            $display("FAIL fault_line: starts=%0d fault=%b, required starts=%0d fault=%b",
                     iss_addr.size(), last_fault, exp_n, exp_f);
        end
        clr();
        fault_addr = '1;
        start_line(64'h2000_0000, 32'h200);
        wait_done(1, 500);
        checks++;
        if (iss_addr.size() !== 16 || last_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_cleared: starts=%0d fault=%b, required starts=16 fault=0", iss_addr.size(), last_fault);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        clr();
        wait_ready();
        wb_addr_i = 64'h3000_0000;
        wb_line_i = mk_line(32'h300);
        wb_req_i  = 1'b1;
        @(posedge clk_i);
        #1;
        wb_addr_i = 64'h3000_0040;
        wb_line_i = mk_line(32'h400);
        while (acc_cyc.size() < 2 && n < 1000) begin
            step();
            n++;
        end
        wb_req_i = 1'b0;
        wait_done(2, 500);
        checks++;
        if (acc_cyc.size() !== 2 || done_cyc.size() < 1 || acc_cyc[1] !== done_cyc[0] + 1) begin
            errors++;
            $display("FAIL b2b_accept: accepts=%0d second_accept_cyc=%0d first_done_cyc=%0d, required accept at done+1",
                     acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] : -1, (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        checks++;
        if (iss_addr.size() !== 32) begin
            errors++;
            $display("FAIL b2b_count: got %0d starts, required 32", iss_addr.size());
        end else begin
            checks++;
            if (iss_addr[16] !== 64'h3000_0040 || iss_data[16] !== 32'h400 ||
                iss_addr[31] !== 64'h3000_007C || iss_data[31] !== 32'h40F) begin
                errors++;
                $display("FAIL b2b_second_line: w0 %h/%h w15 %h/%h, required 3000_0040/400 3000_007c/40f",
                         iss_addr[16], iss_data[16], iss_addr[31], iss_data[31]);
            end
        end

        clr();
        start_line(64'h4000_0000, 32'h500);
        wait_issued(3);
        wb_addr_i = 64'h5000_0000;
        wb_req_i  = 1'b1;
        step();
        wb_req_i  = 1'b0;
        wait_done(1, 500);
        repeat (20) step();
        checks++;
        if (acc_cyc.size() !== 1 || iss_addr.size() !== 16 || done_cnt !== 1) begin
            errors++;
            $display("FAIL busy_ignore: accepts=%0d starts=%0d dones=%0d, required 1 16 1",
                     acc_cyc.size(), iss_addr.size(), done_cnt);
        end
    endtask

    task automatic test_stall();
        clr();
        lat = 6;
        start_line(64'h6000_0000, 32'h600);
        wait_done(1, 2000);
        lat = 1;
        checks++;
        if (wide_cnt !== 0 || unstable_cnt !== 0) begin
            errors++;
            $display("FAIL stall_stability: wide_starts=%0d unstable_cycles=%0d, required 0 0", wide_cnt, unstable_cnt);
        end
        checks++;
        if (iss_addr.size() !== 16 || iss_data[15] !== 32'h60F || last_fault !== 1'b0) begin
            errors++;
            $display("FAIL stall_line: starts=%0d last_data=%h fault=%b, required 16 60f 0",
                     iss_addr.size(), iss_data[iss_addr.size()-1], last_fault);
        end
    endtask

    task automatic test_reset_mid();
        clr();
        start_line(64'h7000_0000, 32'h700);
        wait_issued(8);
        arst_i = 1'b1;
        #1;
        checks++;
        if (wb_ready_o !== 1'b1 || wb_done_o !== 1'b0 || wb_fault_o !== 1'b0 ||
            axi_start_write_o !== 1'b0 || axi_addr_o !== '0 || axi_data_o !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b done=%b fault=%b start=%b addr=%h data=%h, required 1 0 0 0 0 0",
                     wb_ready_o, wb_done_o, wb_fault_o, axi_start_write_o, axi_addr_o, axi_data_o);
        end
        repeat (2) step();
        arst_i = 1'b0;
        repeat (40) step();
        checks++;
        if (done_cnt !== 0 || iss_addr.size() !== 8) begin
            errors++;
            $display("FAIL midreset_drop: dones=%0d starts=%0d, required 0 8", done_cnt, iss_addr.size());
        end
        clr();
        start_line(64'h7000_0100, 32'h800);
        wait_done(1, 500);
        checks++;
        if (iss_addr.size() !== 16 || iss_addr[0] !== 64'h7000_0100 || iss_data[0] !== 32'h800) begin
            errors++;
            $display("FAIL midreset_restart: starts=%0d first=%h/%h, required 16 7000_0100/800",
                     iss_addr.size(), iss_addr[0], iss_data[0]);
        end
    endtask

`ifdef LINE_WB_RETRY_EN
    task automatic test_retry();
        int w3;
        for (int t = 2; t <= 3; t++) begin
            clr();
            fault_addr = 64'h8000_000C;
            fault_left = t;
            start_line(64'h8000_0000, 32'h900);
            wait_done(1, 500);
            w3 = 0;
            foreach (iss_addr[i]) if (iss_addr[i] == 64'h8000_000C) w3++;
            checks++;
            if (w3 !== 3 || iss_addr.size() !== 18 || last_fault !== (t == 3)) begin
                errors++;
                $display("FAIL retry_%0d: word3_issues=%0d starts=%0d fault=%b, required 3 18 %0d",
                         t, w3, iss_addr.size(), last_fault, (t == 3));
            end
        end
        fault_addr = '1;
        fault_left = 0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_single_fault();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef LINE_WB_RETRY_EN
        test_retry();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_line_writeback.md
Name: axi4_lite_line_writeback

Overview:
- Upstream stage of the AXI4-Lite write master. Accepts a dirty cache-line writeback request from the data cache.
- Splits the line into WORD_WIDTH-bit words and issues them one at a time through the single-word write master's start/addr/data/done interface.
- Reports one completion per line, with an aggregated fault flag.

Parameters:
- ADDR_WIDTH, 64, byte-address width; matches the write master's AXI_ADDR_WIDTH.
- WORD_WIDTH, 32, data width per AXI write; matches the write master's AXI_DATA_WIDTH.
- LINE_WIDTH, 512, cache line width in bits; must be an integer multiple of WORD_WIDTH.
- Derived localparams: WORDS = LINE_WIDTH/WORD_WIDTH (16), WORD_BYTES = WORD_WIDTH/8, OFFS = log2(LINE_WIDTH/8).

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- wb_req_i  in  1  writeback request valid
- wb_addr_i  in  ADDR_WIDTH  line address; low OFFS bits ignored
- wb_line_i  in  LINE_WIDTH  line data; word k = bits [k*WORD_WIDTH +: WORD_WIDTH]
- wb_ready_o  out  1  block idle, can accept a request
- wb_done_o  out  1  one-cycle pulse: whole line written
- wb_fault_o  out  1  valid with wb_done_o: at least one word got a SLVERR/DECERR response
- axi_start_write_o  out  1  one-cycle start pulse to the write master
- axi_addr_o  out  ADDR_WIDTH  word byte address to the write master
- axi_data_o  out  WORD_WIDTH  word data to the write master
- axi_done_i  in  1  write master done
- axi_write_fault_i  in  1  write master fault; sampled only when axi_done_i=1

Behaviour:
- Reset: state=IDLE, counter=0, sticky fault=0, line/addr registers=0.
- Reset output values: wb_ready_o=1, wb_done_o=0, wb_fault_o=0, axi_start_write_o=0, axi_addr_o=0, axi_data_o=0.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: wb_ready_o=1.
  - On wb_req_i: latch wb_line_i, latch wb_addr_i with low OFFS bits zeroed, set cnt=0 and sticky=0, go to ISSUE.
  - wb_ready_o is 0 in every other state; requests are ignored there. The requester holds wb_req_i until it sees wb_ready_o.
- ISSUE: axi_start_write_o=1 for exactly this one cycle, then go to WAIT.
  - The start pulse is never wider than one cycle; the write master restarts if start stays high.
- WAIT:
  - On axi_done_i: sticky |= axi_write_fault_i.
  - If cnt==WORDS-1, go to FINISH; otherwise cnt++ and go to ISSUE.
- FINISH: wb_done_o=1 and wb_fault_o=sticky for one cycle, then go to IDLE.
- axi_addr_o = base + cnt*WORD_BYTES; axi_data_o = line word[cnt].
  - Both are registered or driven from the latched state.
  - Both stay stable from the ISSUE cycle through the axi_done_i cycle, because the write master samples data one cycle after start.
- Word order is ascending (word 0 first). Address arithmetic is modulo 2^ADDR_WIDTH with no wrap check, since a line never crosses 2^ADDR_WIDTH when aligned.
- A fault does not abort the line; the remaining words are still written.
- Latency: each word costs 1 ISSUE cycle plus the master's round trip. FINISH costs 1 cycle. wb_done_o comes 1 cycle after the last axi_done_i.
- axi_done_i outside WAIT is ignored. wb_req_i arriving in the same cycle as FINISH is not accepted; it is accepted in the next cycle, in IDLE.
- Reset mid-operation returns to IDLE immediately and drops the line with no wb_done_o. The write master shares arst_i, so no write is left half-issued.

Optional Feature:
- Macro: LINE_WB_RETRY_EN.
- Defined:
  - In WAIT, axi_done_i with axi_write_fault_i=1 and retry count < 2: retry count++ and go back to ISSUE with the same cnt. sticky is not set.
  - Once the retry count reaches 2, a further fault sets sticky and the block advances to the next word.
  - The retry count clears whenever cnt advances.
- Undefined: no retry logic or counter is present, and behaviour is exactly as above.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - the AXI response encodings (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - the t_wb_state enum;
  - the default width constants.
- No sub-module: the word mux and counter are inline. A behavioural write-master/slave model lives only in the testbench.

Test Plan:
- Basic line: wb_addr_i=0x1000_0047, line words 0..15 = 0xA0+k, slave always OKAY -> 16 start pulses at addresses 0x1000_0040..0x1000_007C step 4, data 0xA0..0xAF in order, one wb_done_o with wb_fault_o=0.
- Single fault: slave returns SLVERR on word 5 only -> all 16 words still issued, wb_done_o=1 with wb_fault_o=1. Next line with all OKAY -> wb_fault_o=0 (sticky cleared).
- Back-to-back and busy: wb_req_i held high across two lines -> second line accepted exactly 1 cycle after the first wb_done_o; a request pulsed while busy is not accepted.
- Start-pulse and stability check: slave stalls AW_READY/W_READY 5 cycles -> axi_start_write_o high exactly 1 cycle per word; axi_addr_o/axi_data_o constant until axi_done_i.
- Reset mid-line: arst_i asserted during word 7 -> wb_ready_o=1, all outputs at reset values, no wb_done_o. A new request afterwards starts again at word 0.
- LINE_WB_RETRY_EN defined, word 3 faults twice then OKAY -> word 3 issued 3 times, wb_fault_o=0. Word 3 faulting three times -> issued 3 times, wb_fault_o=1.
